// File: rtl/tb_multi_hart_exit_monitor_if.sv
// Channel status / control bundle between the testbench core subsystem and the exit monitor.
// master = subsystem side (drives channel status), slave = monitor side.
interface tb_multi_hart_exit_monitor_if #(
   parameter int NUM_CH     = 4,
   parameter int CNT_WIDTH  = 32,
   parameter int EXIT_WIDTH = 32
);
   localparam int FF_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0]            ch_pass_i;
   logic [NUM_CH-1:0]            ch_fail_i;
   logic [NUM_CH-1:0]            ch_exit_valid_i;
   logic [NUM_CH*EXIT_WIDTH-1:0] ch_exit_value_i;
   logic [CNT_WIDTH-1:0]         max_cycles_i;
   logic                         run_o;
   logic                         done_o;
   logic [1:0]                   result_o;
   logic [NUM_CH-1:0]            ch_done_o;
   logic [NUM_CH-1:0]            ch_failed_o;
   logic [FF_W-1:0]              first_fail_ch_o;
   logic [EXIT_WIDTH-1:0]        first_fail_value_o;
   logic [CNT_WIDTH-1:0]         tat_cnt_o;

   modport master (
      output ch_pass_i, ch_fail_i, ch_exit_valid_i, ch_exit_value_i, max_cycles_i,
      input  run_o, done_o, result_o, ch_done_o, ch_failed_o,
             first_fail_ch_o, first_fail_value_o, tat_cnt_o
   );

   modport slave (
      input  ch_pass_i, ch_fail_i, ch_exit_valid_i, ch_exit_value_i, max_cycles_i,
      output run_o, done_o, result_o, ch_done_o, ch_failed_o,
             first_fail_ch_o, first_fail_value_o, tat_cnt_o
   );
endinterface

// File: rtl/tb_multi_hart_exit_monitor.sv
// Multi-channel testbench exit monitor: release sequencing, sticky per-channel status, drain window.
// Optional cycle watchdog on max_cycles_i is built only when TB_MONITOR_WATCHDOG_EN is defined.
module tb_multi_hart_exit_monitor #(
   parameter int NUM_CH            = 4,
   parameter int CNT_WIDTH         = 32,
   parameter int EXIT_WIDTH        = 32,
   parameter int RESET_WAIT_CYCLES = 4,
   parameter int DRAIN_CYCLES      = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   tb_multi_hart_exit_monitor_if.slave bus
);
   localparam int FF_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int WW   = (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES) : 1;
   localparam int DW   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [WW-1:0] WAIT_LAST  = WW'(RESET_WAIT_CYCLES - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
   localparam logic [1:0] RES_PASS    = 2'd1;
   localparam logic [1:0] RES_FAIL    = 2'd2;
   localparam logic [1:0] RES_TIMEOUT = 2'd3;

   typedef enum logic [1:0] {S_WAIT, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                r_state, w_state_nxt;
   logic                  r_run, w_run_nxt;
   logic                  r_done, w_done_nxt;
   logic [1:0]            r_result, w_result_nxt;
   logic [WW-1:0]         r_wait_cnt, w_wait_nxt;
   logic [DW-1:0]         r_drain_cnt, w_drain_nxt;
   logic [CNT_WIDTH-1:0]  r_tat, w_tat_nxt;
   logic [NUM_CH-1:0]     r_ch_done, r_ch_failed;
   logic [FF_W-1:0]       r_ff_ch, w_sel_ch;
   logic [EXIT_WIDTH-1:0] r_ff_val, w_sel_val;

   logic                  w_track, w_go_done, w_all_done, w_any_fail;
   logic [NUM_CH-1:0]     w_exit_nz, w_fail_raw, w_pass_raw, w_fail_ev, w_pass_ev;
   logic [NUM_CH-1:0]     w_ch_done_nxt, w_ch_failed_nxt;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

`ifdef TB_MONITOR_WATCHDOG_EN
   logic w_wd_hit;
   assign w_wd_hit = (bus.max_cycles_i != '0) &&
                     (({1'b0, r_tat} + 1'b1) >= {1'b0, bus.max_cycles_i});
`else
   logic w_unused_max;
   assign w_unused_max = ^bus.max_cycles_i;
`endif

   always_comb begin
      w_exit_nz = '0;
      for (int k = 0; k < NUM_CH; k++)
         w_exit_nz[k] = |bus.ch_exit_value_i[k*EXIT_WIDTH +: EXIT_WIDTH];
   end

   // Events only count while cores run and only for channels still open; fail beats pass.
   assign w_track         = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign w_fail_raw      = bus.ch_fail_i | (bus.ch_exit_valid_i & w_exit_nz);
   assign w_pass_raw      = bus.ch_pass_i | (bus.ch_exit_valid_i & ~w_exit_nz);
   assign w_fail_ev       = w_track ? (w_fail_raw & ~r_ch_done) : '0;
   assign w_pass_ev       = w_track ? (w_pass_raw & ~w_fail_raw & ~r_ch_done) : '0;
   assign w_ch_done_nxt   = r_ch_done | w_fail_ev | w_pass_ev;
   assign w_ch_failed_nxt = r_ch_failed | w_fail_ev;
   assign w_all_done      = &w_ch_done_nxt;
   assign w_any_fail      = |w_ch_failed_nxt;

   // Descending scan so the lowest failing index is the one left standing.
   always_comb begin
      w_sel_ch  = '0;
      w_sel_val = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (w_fail_ev[k]) begin
            w_sel_ch  = FF_W'(k);
            w_sel_val = (bus.ch_exit_valid_i[k] && w_exit_nz[k]) ?
                        bus.ch_exit_value_i[k*EXIT_WIDTH +: EXIT_WIDTH] : '0;
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_run_nxt    = r_run;
      w_done_nxt   = r_done;
      w_result_nxt = r_result;
      w_wait_nxt   = r_wait_cnt;
      w_drain_nxt  = r_drain_cnt;
      w_tat_nxt    = r_tat;
      w_go_done    = 1'b0;
      case (r_state)
         S_WAIT: begin
            if (r_wait_cnt == WAIT_LAST) begin
               w_state_nxt = S_RUN;
               w_run_nxt   = 1'b1;
            end else begin
               w_wait_nxt = r_wait_cnt + 1'b1;
            end
         end
         S_RUN: begin
            w_tat_nxt = sat_inc(r_tat);
            if (w_all_done) begin
               w_go_done = 1'b1;
            end else if (w_any_fail) begin
               if (DRAIN_CYCLES == 0) begin
                  w_go_done = 1'b1;
               end else begin
                  w_state_nxt = S_DRAIN;
                  w_drain_nxt = '0;
               end
            end
`ifdef TB_MONITOR_WATCHDOG_EN
            else if (w_wd_hit) begin
               w_go_done = 1'b1;
            end
`endif
         end
         S_DRAIN: begin
            w_tat_nxt = sat_inc(r_tat);
            if (w_all_done || (r_drain_cnt == DRAIN_LAST)) w_go_done = 1'b1;
            else w_drain_nxt = r_drain_cnt + 1'b1;
         end
         default: ;
      endcase
      if (w_go_done) begin
         w_state_nxt  = S_DONE;
         w_run_nxt    = 1'b0;
         w_done_nxt   = 1'b1;
         w_result_nxt = w_any_fail ? RES_FAIL : (w_all_done ? RES_PASS : RES_TIMEOUT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_WAIT;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run       <= 1'b0;
         r_done      <= 1'b0;
         r_result    <= '0;
         r_wait_cnt  <= '0;
         r_drain_cnt <= '0;
         r_tat       <= '0;
         r_ch_done   <= '0;
         r_ch_failed <= '0;
         r_ff_ch     <= '0;
         r_ff_val    <= '0;
      end else begin
         r_run       <= w_run_nxt;
         r_done      <= w_done_nxt;
         r_result    <= w_result_nxt;
         r_wait_cnt  <= w_wait_nxt;
         r_drain_cnt <= w_drain_nxt;
         r_tat       <= w_tat_nxt;
         r_ch_done   <= w_ch_done_nxt;
         r_ch_failed <= w_ch_failed_nxt;
         if ((w_fail_ev != '0) && (r_ch_failed == '0)) begin
            r_ff_ch  <= w_sel_ch;
            r_ff_val <= w_sel_val;
         end
      end
   end

   assign bus.run_o              = r_run;
   assign bus.done_o             = r_done;
   assign bus.result_o           = r_result;
   assign bus.ch_done_o          = r_ch_done;
   assign bus.ch_failed_o        = r_ch_failed;
   assign bus.first_fail_ch_o    = r_ff_ch;
   assign bus.first_fail_value_o = r_ff_val;
   assign bus.tat_cnt_o          = r_tat;
endmodule

// File: doc/tb_multi_hart_exit_monitor.md
Name: tb_multi_hart_exit_monitor

Overview:
- Parametrised successor to the single-core testbench exit/abort logic.
- Sits between the clock/reset generator and an NUM_CH-channel core subsystem in the testbench.
- Sequences release after reset, tracks the pass/fail/exit status of each channel with sticky flags, and runs a cycle watchdog.
- Reports one aggregated result, plus the turnaround cycle count, for the top level to print and act on with $finish.

Parameters:
- NUM_CH, 4, number of monitored cores/channels (1..32)
- CNT_WIDTH, 32, width of cycle counters and max_cycles_i
- EXIT_WIDTH, 32, width of each channel's exit value
- RESET_WAIT_CYCLES, 4, cycles after rst_n deassertion before run_o rises (>=1)
- DRAIN_CYCLES, 16, cycles allowed after the first failure for the other channels to finish (>=0)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ch_pass_i  in  NUM_CH  per-channel tests-passed pulse/level
- ch_fail_i  in  NUM_CH  per-channel tests-failed pulse/level
- ch_exit_valid_i  in  NUM_CH  per-channel exit strobe
- ch_exit_value_i  in  NUM_CH*EXIT_WIDTH  per-channel exit value; channel k is at [k*EXIT_WIDTH +: EXIT_WIDTH]
- max_cycles_i  in  CNT_WIDTH  watchdog limit; 0 disables the watchdog
- run_o  out  1  fetch-enable to all cores
- done_o  out  1  sticky, set when the monitor has finished
- result_o  out  2  0=NONE, 1=PASS, 2=FAIL, 3=TIMEOUT
- ch_done_o  out  NUM_CH  sticky per-channel completion flags
- ch_failed_o  out  NUM_CH  sticky per-channel failure flags
- first_fail_ch_o  out  $clog2(NUM_CH) (min 1)  index of the first failing channel
- first_fail_value_o  out  EXIT_WIDTH  exit value of the first failing channel; 0 if the failure came from ch_fail_i
- tat_cnt_o  out  CNT_WIDTH  count of cycles spent in RUN

Behaviour:
- Reset (asynchronous, rst_n=0): state=WAIT, every output 0, all internal counters 0. Reset asserted mid-operation returns the block to this state immediately, including from DONE.
- WAIT:
  - Counts cycles while run_o=0.
  - After RESET_WAIT_CYCLES rising edges: state=RUN and run_o=1 (registered).
  - Channel inputs are ignored in WAIT.
- RUN:
  - tat_cnt_o increments every cycle and saturates at all-ones.
  - A channel that is not yet done, sampled each edge:
    - Fail event: ch_fail_i=1, or ch_exit_valid_i=1 with a nonzero value. Sets ch_done and ch_failed.
    - Pass event: ch_pass_i=1, or ch_exit_valid_i=1 with value 0. Sets ch_done only.
    - Fail and pass in the same cycle: fail wins.
  - Once ch_done is set for a channel, further events on it are ignored.
  - The first failure latches first_fail_ch_o and first_fail_value_o. If several channels fail in the same cycle, the lowest index wins.
- RUN transitions, in priority order, evaluated on the same edge that updates the flags:
  1. All channels done → DONE.
  2. Any failure → DRAIN, with the drain counter cleared. If DRAIN_CYCLES=0, go directly to DONE.
  3. Watchdog hit (max_cycles_i!=0 and tat_cnt_o+1 >= max_cycles_i) → DONE with result TIMEOUT.
- DRAIN:
  - run_o stays 1, tat_cnt_o keeps counting, and channel tracking continues.
  - Exits to DONE when all channels are done or after DRAIN_CYCLES cycles, whichever comes first.
  - The watchdog is not evaluated in DRAIN.
- DONE:
  - run_o=0 on the same edge, done_o=1.
  - result_o: FAIL if any ch_failed is set; otherwise PASS if all channels are done; otherwise TIMEOUT.
  - State, flags and counters freeze; only reset leaves DONE.
- All outputs are registered. A completion event is visible on done_o exactly one cycle after the input is sampled.

Optional Feature:
- Macro: TB_MONITOR_WATCHDOG_EN.
- Defined: watchdog as described above.
- Undefined: max_cycles_i is ignored, TIMEOUT is produced only when a channel never finishes, which cannot occur on its own (the monitor waits indefinitely), and no watchdog comparator is built.

Test Plan:
1. NUM_CH=4, no events, rst_n released at t0 → run_o=0 for 4 edges, rises on the 4th edge; tat_cnt_o=0 at the rise.
2. Channels 0..3 each pass once at RUN cycles 10, 20, 30, 40 (exit value 0 on channel 2) → done_o=1 one cycle after cycle 40; result_o=1; ch_failed_o=0; tat_cnt_o=41.
3. Channel 1 exits with 5 and channel 3 asserts ch_fail_i in the same cycle, others silent, DRAIN_CYCLES=16 → result_o=2; first_fail_ch_o=1; first_fail_value_o=5; done_o rises 16 cycles later; run_o drops on the same edge.
4. Channel 0 asserts pass and fail in the same cycle → ch_failed_o[0]=1; a later pass on channel 0 is ignored.
5. With the watchdog macro defined, max_cycles_i=100, no events → result_o=3; done_o=1 with tat_cnt_o=100. With max_cycles_i=0 there is no timeout after 1000 cycles.
6. rst_n asserted mid-DRAIN → all outputs 0 asynchronously; after release the WAIT sequence repeats and all flags are cleared.
